// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sumador_pkg
// Description : Shared definitions for the sumador_pipe adder/subtractor.
//               Holds the op encoding and the reference payload layout
//               {sum, carry, ovf, idx} carried through every pipeline stage.
//               The layout uses the default widths; sumador_pipe declares
//               the same layout sized to its own WIDTH/IDX_W parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package sumador_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_IDX_W = 4;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 carry;
        logic                 ovf;
        logic [DEF_IDX_W-1:0] idx;
    } payload_t;

endpackage : sumador_pkg
`default_nettype wire

// File: rtl/sumador_stage.sv
`default_nettype none
// ============================================================================
// Module      : sumador_stage
// Description : One elastic register stage (valid bit plus payload).
//               The stage loads from upstream whenever it is empty or is
//               being emptied downstream in the same cycle, so a full
//               pipeline keeps streaming at one item per cycle.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               up_valid_i/up_ready_o  - upstream handshake
//               up_data_i              - upstream payload
//               dn_valid_o/dn_ready_i  - downstream handshake
//               dn_data_o              - registered payload
// Revision    : 1.0 - initial release
// ============================================================================
module sumador_stage
    import sumador_pkg::*;
#(
    parameter type PAYLOAD_T = payload_t
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     up_valid_i,
    output logic     up_ready_o,
    input  PAYLOAD_T up_data_i,
    output logic     dn_valid_o,
    input  logic     dn_ready_i,
    output PAYLOAD_T dn_data_o
);

    logic     valid_q, valid_d;
    PAYLOAD_T data_q,  data_d;
    logic     w_load;

    // Empty, or the held item leaves this cycle: either way a slot is free.
    assign w_load     = !valid_q || dn_ready_i;
    assign up_ready_o = w_load;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (w_load) begin
            valid_d = up_valid_i;
            // Payload only changes on a real transfer, so outputs stay quiet
            // while the stage drains to empty.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : sumador_stage
`default_nettype wire

// File: rtl/sumador_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sumador_pipe
// Description : Elastic pipelined adder/subtractor with carry, signed
//               overflow and a pass-through tag. The arithmetic is computed
//               combinationally in front of the first register stage; STAGES
//               elastic stages follow with valid/ready flow control.
// Ports       : clk, reset                    - clock, sync active-high reset
//               in_valid/in_ready             - input handshake
//               dataA, dataB, op, idx         - operands, 0=add 1=sub, tag
//               out_valid/out_ready           - output handshake
//               sum_dd, carry_dd, ovf_dd, idx_dd - registered results
// Config      : SUMADOR_SAT_EN - when defined, unsigned saturation of sum
//               (carry/ovf still report the unsaturated flags).
// Revision    : 1.0 - initial release
// ============================================================================
module sumador_pipe
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             op,
    input  logic [IDX_W-1:0] idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_dd,
    output logic             carry_dd,
    output logic             ovf_dd,
    output logic [IDX_W-1:0] idx_dd
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic [IDX_W-1:0] idx;
    } pay_t;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;

    // Subtract as A + ~B + 1; carry out then means "no borrow".
    assign w_b_eff = (op == OP_SUB) ? ~dataB : dataB;
    assign w_full  = {1'b0, dataA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, op};
    assign w_carry = w_full[WIDTH];
    assign w_ovf   = (dataA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_full[WIDTH-1] != dataA[WIDTH-1]);

`ifdef SUMADOR_SAT_EN
    always_comb begin
        w_sum = w_full[WIDTH-1:0];
        if ((op == OP_ADD) && w_carry) begin
            w_sum = {WIDTH{1'b1}};
        end else if ((op == OP_SUB) && !w_carry) begin
            w_sum = '0;
        end
    end
`else
    assign w_sum = w_full[WIDTH-1:0];
`endif

    // Handshake chain: index k is the link feeding stage k; index STAGES is
    // the output port.
    logic [STAGES:0] w_valid;
    logic [STAGES:0] w_ready;
    pay_t            w_data [STAGES+1];

    assign w_valid[0]      = in_valid;
    assign in_ready        = w_ready[0];
    assign w_data[0]       = '{sum: w_sum, carry: w_carry, ovf: w_ovf, idx: idx};
    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sumador_stage #(
            .PAYLOAD_T (pay_t)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .up_valid_i (w_valid[k]),
            .up_ready_o (w_ready[k]),
            .up_data_i  (w_data[k]),
            .dn_valid_o (w_valid[k+1]),
            .dn_ready_i (w_ready[k+1]),
            .dn_data_o  (w_data[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign sum_dd    = w_data[STAGES].sum;
    assign carry_dd  = w_data[STAGES].carry;
    assign ovf_dd    = w_data[STAGES].ovf;
    assign idx_dd    = w_data[STAGES].idx;

endmodule : sumador_pipe
`default_nettype wire

// File: tb/tb_sumador_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumador_pipe
// Description : Self-checking bench for sumador_pipe (WIDTH=4, STAGES=2).
//               Directed vector table, stall stream, reset flush and a
//               randomized run, all checked against an arithmetic model with
//               an in-order queue of outstanding operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumador_pipe;

    localparam int W  = 4;
    localparam int ST = 2;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dataA, dataB;
    logic          op;
    logic [IW-1:0] idx;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum_dd;
    logic          carry_dd, ovf_dd;
    logic [IW-1:0] idx_dd;

    sumador_pipe #(.WIDTH(W), .STAGES(ST), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .op        (op),
        .idx       (idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_dd    (sum_dd),
        .carry_dd  (carry_dd),
        .ovf_dd    (ovf_dd),
        .idx_dd    (idx_dd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int sum;
        int carry;
        int ovf;
        int idx;
        int acc;   // edge number at which the op was accepted
    } item_t;

    item_t q[$];
    int    cyc = 0;

    // Plain-arithmetic reference for a 4-bit add/subtract.
    function automatic item_t ref_calc(input int a, input int b, input bit sub, input int tag);
        item_t r;
        int sa, sb, u, s;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (!sub) begin
            u = a + b;  s = sa + sb;  r.carry = (u >= 16) ? 1 : 0;
        end else begin
            u = a - b;  s = sa - sb;  r.carry = (a >= b) ? 1 : 0;
        end
        r.sum = u & 15;
        r.ovf = (s > 7 || s < -8) ? 1 : 0;
`ifdef SUMADOR_SAT_EN
        if (!sub && r.carry == 1) r.sum = 15;
        if (sub && r.carry == 0)  r.sum = 0;
`endif
        r.idx = tag;
        r.acc = 0;
        return r;
    endfunction

    bit           prev_stall = 0;
    logic [W-1:0] p_sum;
    logic         p_carry, p_ovf;
    logic [IW-1:0] p_idx;
    int           recv_cnt = 0;

    // Called at a negedge with inputs already driven; returns at the next
    // negedge after updating the model for the intervening rising edge.
    task automatic step(output bit accepted);
        bit in_x, out_x;
        item_t it;
        #1;
        if (!reset) begin
            chk("in_ready", int'(in_ready), (q.size() == ST && !out_ready) ? 0 : 1);
            chk("out_valid", int'(out_valid),
                (q.size() > 0 && cyc >= q[0].acc + ST) ? 1 : 0);
            if (out_valid && q.size() > 0) begin
                chk("sum",   int'(sum_dd),   q[0].sum);
                chk("carry", int'(carry_dd), q[0].carry);
                chk("ovf",   int'(ovf_dd),   q[0].ovf);
                chk("idx",   int'(idx_dd),   q[0].idx);
            end
            if (prev_stall) begin
                chk("stall_hold", int'({sum_dd, carry_dd, ovf_dd, idx_dd}),
                    int'({p_sum, p_carry, p_ovf, p_idx}));
            end
        end
        in_x  = in_valid && in_ready && !reset;
        out_x = out_valid && out_ready && !reset;
        prev_stall = out_valid && !out_ready && !reset;
        {p_sum, p_carry, p_ovf, p_idx} = {sum_dd, carry_dd, ovf_dd, idx_dd};
        it = ref_calc(int'(dataA), int'(dataB), op, int'(idx));
        it.acc = cyc;
        @(posedge clk);
        if (reset) begin
            q.delete();
            prev_stall = 0;
        end else begin
            if (out_x && q.size() > 0) begin
                void'(q.pop_front());
                recv_cnt++;
            end
            if (in_x) q.push_back(it);
        end
        cyc++;
        accepted = in_x;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       op;
        logic [3:0] idx;
        logic [3:0] sum;
        logic       carry, ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit acc;
        int lat;
        int sent;
        bit saw_low;

`ifdef SUMADOR_SAT_EN
        vecs[0] = '{4'h7, 4'h5, 1'b0, 4'd3,  4'hC, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h2, 1'b0, 4'd5,  4'hF, 1'b1, 1'b0};
        vecs[2] = '{4'h3, 4'h5, 1'b1, 4'd9,  4'h0, 1'b0, 1'b0};
        vecs[3] = '{4'h8, 4'h8, 1'b0, 4'd1,  4'hF, 1'b1, 1'b1};
`else
        vecs[0] = '{4'h7, 4'h5, 1'b0, 4'd3,  4'hC, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h2, 1'b0, 4'd5,  4'h1, 1'b1, 1'b0};
        vecs[2] = '{4'h3, 4'h5, 1'b1, 4'd9,  4'hE, 1'b0, 1'b0};
        vecs[3] = '{4'h8, 4'h8, 1'b0, 4'd1,  4'h0, 1'b1, 1'b1};
`endif
        vecs[4] = '{4'h8, 4'h1, 1'b1, 4'd2,  4'h7, 1'b1, 1'b1};
        vecs[5] = '{4'h5, 4'h5, 1'b1, 4'd15, 4'h0, 1'b1, 1'b0};

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        dataA = 4'h9; dataB = 4'h3; op = 1'b0; idx = 4'hA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_outputs", int'({sum_dd, carry_dd, ovf_dd, idx_dd}), 0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed table: one op at a time, latency and fields checked.
        foreach (vecs[i]) begin
            dataA = vecs[i].a; dataB = vecs[i].b; op = vecs[i].op; idx = vecs[i].idx;
            in_valid = 1'b1;
            step(acc);
            chk("vec_accept", int'(acc), 1);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                step(acc);
                lat++;
            end
            chk("vec_latency", lat, ST);
            chk("vec_sum",   int'(sum_dd),   int'(vecs[i].sum));
            chk("vec_carry", int'(carry_dd), int'(vecs[i].carry));
            chk("vec_ovf",   int'(ovf_dd),   int'(vecs[i].ovf));
            chk("vec_idx",   int'(idx_dd),   int'(vecs[i].idx));
            step(acc);
        end

        // Back-to-back stream of 16 with out_ready low during cycles 4..7.
        sent = 0; saw_low = 0; recv_cnt = 0;
        for (int c = 0; c < 60 && (sent < 16 || q.size() > 0); c++) begin
            in_valid  = (sent < 16);
            dataA = 4'($urandom); dataB = 4'($urandom); op = 1'($urandom);
            idx       = 4'(sent);
            out_ready = !(c >= 4 && c <= 7);
            #1;
            if (in_valid && !in_ready) saw_low = 1;
            step(acc);
            if (acc) sent++;
        end
        chk("stream_sent", sent, 16);
        chk("stream_recv", recv_cnt, 16);
        chk("stream_backpressure", int'(saw_low), 1);
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset with two operations in flight; inputs during reset ignored.
        in_valid = 1'b1; dataA = 4'h6; dataB = 4'h1; op = 1'b0; idx = 4'h4;
        step(acc);
        idx = 4'h5;
        step(acc);
        reset = 1'b1; idx = 4'h6;
        step(acc);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_outputs", int'({sum_dd, carry_dd, ovf_dd, idx_dd}), 0);
        repeat (5) step(acc);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            dataA = 4'($urandom); dataB = 4'($urandom); op = 1'($urandom);
            idx       = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
            step(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) step(acc);
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sumador_pipe
`default_nettype wire

// File: doc/sumador_pipe.md
SUMADOR_PIPE -- requirements
Module: sumador_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, operand and result width in bits (>=2).
REQ-002 The block SHALL expose parameter STAGES, default 2, pipeline depth in register stages (1..8).
REQ-003 The block SHALL expose parameter IDX_W, default 4, tag width carried alongside each operation.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid  input  1  operation present on dataA/dataB/op/idx.
REQ-007 The block SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-008 The block SHALL have ports dataA, dataB  input  WIDTH  operands; op  input  1  0=add, 1=subtract (dataA-dataB).
REQ-009 The block SHALL have port idx  input  IDX_W  tag, returned unmodified with the result.
REQ-010 The block SHALL have ports out_valid  output  1; out_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have ports sum_dd  output  WIDTH; carry_dd  output  1; ovf_dd  output  1; idx_dd  output  IDX_W.

Function
REQ-012 Transfer SHALL occur on a port when valid and ready are both 1 at a rising clk edge; no other condition transfers data.
REQ-013 Stage 0 SHALL compute sum = dataA + (op ? ~dataB : dataB) + op, modulo 2^WIDTH; carry = bit WIDTH of that (WIDTH+1)-bit result (for subtract, carry=1 means no borrow).
REQ-014 ovf SHALL be signed two's-complement overflow: operands (after inversion for subtract) share a sign bit and the result sign differs.
REQ-015 Each stage k SHALL hold valid_k plus payload and SHALL load from stage k-1 when valid_k=0 or stage k is being emptied this cycle (elastic pipeline, no bubbles under continuous flow).
REQ-016 in_ready SHALL equal (!valid_0 || stage 0 emptying this cycle); out_valid SHALL equal valid of the last stage; outputs SHALL come directly from last-stage registers.
REQ-017 With out_ready held 1, a result SHALL appear at out_valid exactly STAGES cycles after acceptance; throughput SHALL be one operation per cycle.
REQ-018 While out_valid=1 and out_ready=0, sum_dd/carry_dd/ovf_dd/idx_dd SHALL hold stable; upstream stages fill, and in_ready SHALL drop only when all STAGES are valid.
REQ-019 Simultaneous accept at input and emit at output with a full pipe SHALL be lossless: in_ready=1 in that cycle.
REQ-020 Results SHALL leave in acceptance order; no operation SHALL be duplicated or dropped.

Reset
REQ-021 While reset=1 at a clk edge, all valid bits SHALL clear and sum_dd, carry_dd, ovf_dd, idx_dd SHALL be 0; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight operations; inputs presented during reset SHALL NOT be accepted.

Configuration
REQ-023 With macro SUMADOR_SAT_EN defined, stage 0 SHALL saturate unsigned: add with carry=1 yields all-ones, subtract with carry=0 yields 0; carry_dd and ovf_dd SHALL still report the unsaturated flags.
REQ-024 Without SUMADOR_SAT_EN, sum_dd SHALL be the wrapped result of REQ-013 and no saturation logic SHALL be present.

Structure
REQ-025 A shared package sumador_pkg SHALL hold the op encoding constants (OP_ADD=0, OP_SUB=1) and the payload struct {sum, carry, ovf, idx}.
REQ-026 One sub-module sumador_stage SHALL implement a single elastic register stage (valid, payload, load/empty handshake), instantiated STAGES times by a generate loop.

Verification (WIDTH=4, STAGES=2, out_ready=1 unless stated)
REQ-027 Add 4'h7+4'h5, idx=3 -> two cycles later sum_dd=4'hC, carry_dd=0, ovf_dd=1, idx_dd=3.
REQ-028 Add 4'hF+4'h2 -> sum_dd=4'h1, carry_dd=1, ovf_dd=0; with SUMADOR_SAT_EN sum_dd=4'hF.
REQ-029 Sub 4'h3-4'h5 -> sum_dd=4'hE, carry_dd=0; with SUMADOR_SAT_EN sum_dd=4'h0.
REQ-030 Back-to-back stream idx 0..15, out_ready low cycles 4-7 -> in_ready low once 2 entries held, outputs stable while stalled, all 16 results in order, none lost.
REQ-031 Reset pulse with 2 operations in flight -> out_valid=0 next cycle, outputs 0, no stale result ever emitted.
REQ-032 Every bench run SHALL compare against a behavioural reference model and against the synthesized netlist cycle-by-cycle.
